// File: rtl/fwd_pkg.sv
// Shared types and width helpers for the in-flight result pipeline.
package fwd_pkg;

  // Per-stage status bits; rd and data are held beside these because their widths are parameters.
  typedef struct packed {
    logic valid;
    logic wen;
    logic is_load;
    logic filled;
  } entry_flags_t;

  // Stage-select value reported when no stage matches.
  localparam int SEL_NONE = 0;

  function automatic int sel_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Youngest-match forwarding search for one source operand over all tracked stages.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SELW  = 2
) (
  input  entry_flags_t     flags    [DEPTH],
  input  logic [AW-1:0]    rd       [DEPTH],
  input  logic [XLEN-1:0]  data     [DEPTH],
  input  logic [AW-1:0]    rs,
  output logic             hit,
  output logic [SELW-1:0]  sel,
  output logic [XLEN-1:0]  hit_data,
  output logic             unfilled
);

  always_comb begin
    logic found;
    found    = 1'b0;
    hit      = 1'b0;
    sel      = SELW'(SEL_NONE);
    hit_data = '0;
    unfilled = 1'b0;
    // Stop at the youngest candidate: an unfilled load hides any older producer.
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && flags[i].valid && flags[i].wen && (rd[i] != '0) && (rd[i] == rs)) begin
        found = 1'b1;
        if (flags[i].is_load && !flags[i].filled) begin
          unfilled = 1'b1;
        end else begin
          hit      = 1'b1;
          sel      = SELW'(i);
          hit_data = data[i];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_pipeline.sv
// DEPTH-stage in-flight result pipeline with two-port forwarding, load-use detection and write-back.
// Optional perf counters are built when FWD_PIPELINE_PERF_EN is defined.
module fwd_pipeline
  import fwd_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int DEPTH      = 3,
  parameter  int NREGS      = 32,
  parameter  int LOAD_STAGE = 1,
  localparam int AW         = $clog2(NREGS),
  localparam int SELW       = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  // in_valid is a one-cycle offer with no ready: an offer made while stall=1 is dropped,
  // so the producer must keep presenting it until a non-stalled edge accepts it.
  input  logic             in_valid,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_wen,
  input  logic             in_is_load,
  input  logic [XLEN-1:0]  in_data,
  input  logic             stall,
  input  logic             bubble,
  input  logic [DEPTH-1:0] flush_mask,
  input  logic [XLEN-1:0]  ld_data,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [SELW-1:0]  fwd1_sel,
  output logic [SELW-1:0]  fwd2_sel,
  output logic [XLEN-1:0]  fwd1_data,
  output logic [XLEN-1:0]  fwd2_data,
  output logic             load_use,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [XLEN-1:0]  wb_data
`ifdef FWD_PIPELINE_PERF_EN
  ,
  output logic [31:0]      perf_fwd_cnt,
  output logic [31:0]      perf_lu_cnt
`endif
);

  entry_flags_t     flg    [DEPTH];
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];

  logic unfilled1, unfilled2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        flg[i]    <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (flush_mask[0]) begin
        flg[0] <= '0;
      end else if (!stall) begin
        if (in_valid && !bubble) begin
          flg[0]    <= '{valid: 1'b1, wen: in_wen, is_load: in_is_load, filled: !in_is_load};
          rd_q[0]   <= in_rd;
          data_q[0] <= in_is_load ? '0 : in_data;
        end else begin
          flg[0] <= '0;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (flush_mask[i]) begin
          flg[i] <= '0;
        end else if (!stall) begin
          flg[i]    <= flg[i-1];
          rd_q[i]   <= rd_q[i-1];
          data_q[i] <= data_q[i-1];
          // Memory data arrives for the load moving into the fill stage this edge.
          if (i == LOAD_STAGE && flg[i-1].valid && flg[i-1].is_load && !flg[i-1].filled) begin
            flg[i].filled <= 1'b1;
            data_q[i]     <= ld_data;
          end
        end
      end
    end
  end

  fwd_lookup #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .SELW(SELW)) u_lookup1 (
    .flags    (flg),
    .rd       (rd_q),
    .data     (data_q),
    .rs       (rs1),
    .hit      (fwd1_hit),
    .sel      (fwd1_sel),
    .hit_data (fwd1_data),
    .unfilled (unfilled1)
  );

  fwd_lookup #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .SELW(SELW)) u_lookup2 (
    .flags    (flg),
    .rd       (rd_q),
    .data     (data_q),
    .rs       (rs2),
    .hit      (fwd2_hit),
    .sel      (fwd2_sel),
    .hit_data (fwd2_data),
    .unfilled (unfilled2)
  );

  assign load_use = unfilled1 | unfilled2;

  assign wb_valid = flg[DEPTH-1].valid && flg[DEPTH-1].wen && (rd_q[DEPTH-1] != '0);
  assign wb_rd    = wb_valid ? rd_q[DEPTH-1]   : '0;
  assign wb_data  = wb_valid ? data_q[DEPTH-1] : '0;

`ifdef FWD_PIPELINE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fwd_cnt <= '0;
      perf_lu_cnt  <= '0;
    end else begin
      if ((fwd1_hit || fwd2_hit) && !stall) perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      if (load_use)                         perf_lu_cnt  <= perf_lu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_pipeline.sv
// Directed bench for fwd_pipeline at DEPTH=3, LOAD_STAGE=1; FWD_PIPELINE_PERF_EN adds counter checks.
module tb_fwd_pipeline;

  localparam int XLEN  = 32;
  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int SELW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_wen, in_is_load, stall, bubble;
  logic [AW-1:0]    in_rd, rs1, rs2;
  logic [XLEN-1:0]  in_data, ld_data;
  logic [DEPTH-1:0] flush_mask;
  logic             fwd1_hit, fwd2_hit, load_use, wb_valid;
  logic [SELW-1:0]  fwd1_sel, fwd2_sel;
  logic [XLEN-1:0]  fwd1_data, fwd2_data, wb_data;
  logic [AW-1:0]    wb_rd;
`ifdef FWD_PIPELINE_PERF_EN
  logic [31:0]      perf_fwd_cnt, perf_lu_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fwd_pipeline #(.XLEN(XLEN), .DEPTH(DEPTH), .NREGS(32), .LOAD_STAGE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .in_is_load (in_is_load),
    .in_data    (in_data),
    .stall      (stall),
    .bubble     (bubble),
    .flush_mask (flush_mask),
    .ld_data    (ld_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_sel   (fwd1_sel),
    .fwd2_sel   (fwd2_sel),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data),
    .load_use   (load_use),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
`ifdef FWD_PIPELINE_PERF_EN
    ,
    .perf_fwd_cnt (perf_fwd_cnt),
    .perf_lu_cnt  (perf_lu_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rd, input logic ld, input logic [XLEN-1:0] d);
    in_valid   = v;
    in_wen     = 1'b1;
    in_rd      = rd;
    in_is_load = ld;
    in_data    = d;
  endtask

  // Offer one entry for exactly one edge, then go idle.
  task automatic push(input logic [AW-1:0] rd, input logic ld, input logic [XLEN-1:0] d);
    drive(1'b1, rd, ld, d);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    stall = 1'b0; bubble = 1'b0; flush_mask = '0; ld_data = '0;
    rs1 = 5'd5; rs2 = 5'd7;
    #3;
    chk("rst_hit1", fwd1_hit, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_load_use", load_use, 0);
    #9 rst = 1'b0;

    // Back-to-back writes to x5: youngest wins, then ages into stage 1.
    push(5'd5, 1'b0, 32'h11);
    push(5'd5, 1'b0, 32'h22);
    chk("b2b_hit", fwd1_hit, 1);
    chk("b2b_sel0", fwd1_sel, 0);
    chk("b2b_data0", fwd1_data, 32'h22);
    tick();
    chk("age_sel1", fwd1_sel, 1);
    chk("age_data1", fwd1_data, 32'h22);
    chk("wb_x5_first_rd", wb_rd, 5);
    chk("wb_x5_first_data", wb_data, 32'h11);
    tick();
    chk("wb_x5_valid", wb_valid, 1);
    chk("wb_x5_data", wb_data, 32'h22);
    tick();
    chk("drain_wb_valid", wb_valid, 0);

    // Older ALU x7 then load x7: the unfilled load hides the ALU result.
    push(5'd7, 1'b0, 32'h1);
    push(5'd7, 1'b1, 32'h999);
    chk("lu_flag", load_use, 1);
    chk("lu_hit2", fwd2_hit, 0);
    ld_data = 32'hDEAD;
    tick();
    ld_data = 32'h0;
    chk("fill_hit2", fwd2_hit, 1);
    chk("fill_sel2", fwd2_sel, 1);
    chk("fill_data2", fwd2_data, 32'hDEAD);
    chk("fill_lu_clear", load_use, 0);
    chk("wb_alu_x7", wb_data, 32'h1);
    tick();
    chk("wb_load_rd", wb_rd, 7);
    chk("wb_load_data", wb_data, 32'hDEAD);
    tick();

    // Writes to x0 never forward and never write back.
    rs1 = 5'd0;
    push(5'd0, 1'b0, 32'h77);
    chk("x0_hit", fwd1_hit, 0);
    tick(); tick();
    chk("x0_wb_valid", wb_valid, 0);
    tick();

    // Fill, stall with a dropped offer, then flush under stall.
    push(5'd1, 1'b0, 32'hA);
    push(5'd2, 1'b0, 32'hB);
    push(5'd3, 1'b0, 32'hC);
    stall = 1'b1;
    drive(1'b1, 5'd4, 1'b0, 32'hD);
    tick(); tick(); tick();
    rs1 = 5'd3; rs2 = 5'd2;
    #1;
    chk("stall_sel1", fwd1_sel, 0);
    chk("stall_data1", fwd1_data, 32'hC);
    chk("stall_sel2", fwd2_sel, 1);
    chk("stall_data2", fwd2_data, 32'hB);
    chk("stall_wb_rd", wb_rd, 1);
    chk("stall_wb_data", wb_data, 32'hA);
    rs1 = 5'd4;
    #1;
    chk("stall_drop_hit", fwd1_hit, 0);
    in_valid = 1'b0;
    rs1 = 5'd3;
    flush_mask = 3'b011;
    tick();
    chk("flush_hit1", fwd1_hit, 0);
    chk("flush_hit2", fwd2_hit, 0);
    chk("flush_held_wb_rd", wb_rd, 1);
    chk("flush_held_wb_data", wb_data, 32'hA);
    flush_mask = 3'b111;
    tick();
    chk("flush_all_wb", wb_valid, 0);
    flush_mask = '0;
    stall = 1'b0;

    // Bubble suppresses a valid offer; x3=5 reaches write-back two edges after entry.
    rs1 = 5'd9;
    bubble = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 32'h99);
    tick();
    chk("bubble_hit", fwd1_hit, 0);
    bubble = 1'b0;
    rs1 = 5'd3;
    push(5'd3, 1'b0, 32'h5);
    chk("x3_sel0", fwd1_sel, 0);
    tick();
    chk("x3_not_wb_yet", wb_valid, 0);
    tick();
    chk("x3_wb_valid", wb_valid, 1);
    chk("x3_wb_rd", wb_rd, 3);
    chk("x3_wb_data", wb_data, 32'h5);
    tick();

    // Asynchronous reset mid-cycle while full and stalled.
    push(5'd10, 1'b0, 32'h10);
    push(5'd11, 1'b0, 32'h11);
    push(5'd12, 1'b0, 32'h12);
    rs1 = 5'd12; rs2 = 5'd10;
    #1;
    chk("full_hit1", fwd1_hit, 1);
    stall = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_hit1", fwd1_hit, 0);
    chk("arst_hit2", fwd2_hit, 0);
    chk("arst_wb_valid", wb_valid, 0);
`ifdef FWD_PIPELINE_PERF_EN
    chk("arst_perf_fwd", perf_fwd_cnt, 0);
    chk("arst_perf_lu", perf_lu_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    tick();
    chk("post_rst_hit1", fwd1_hit, 0);
    chk("post_rst_wb", wb_valid, 0);

`ifdef FWD_PIPELINE_PERF_EN
    // Two cycles with a forward hit and one cycle with a pending load.
    rs1 = 5'd6; rs2 = 5'd8;
    push(5'd6, 1'b0, 32'h6);
    push(5'd8, 1'b1, 32'h0);
    tick();
    chk("perf_fwd_cnt", perf_fwd_cnt, 2);
    chk("perf_lu_cnt", perf_lu_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
